adc_stepper_ctrl: RTL and testbench

//  Multi-channel ADC0809-style scan sequencer driving a stepper motor.

---
 rtl/adc_stepper_pkg.sv | 46 ++++
 rtl/adc_stepper_ctrl_step_phase_gen.sv | 82 ++++++++
 rtl/adc_stepper_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_adc_stepper_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_stepper_pkg.sv
// Shared types and constants for the ADC scan sequencer and stepper phase generator.
//  - adc_state_t  : ADC handshake FSM states
//  - MODE_*       : step-mode encodings (3 is treated as full)
//  - CENTRE       : ch0 value that means zero speed
//  - half_pat     : 8-entry half-step coil table, bit order A,B,/A,/B
//  - step_pattern : coil pattern for an index under a given mode
package adc_stepper_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ALE,
      S_START,
      S_WBUSY,
      S_WEOC,
      S_READ,
      S_NEXT
   } adc_state_t;

   localparam logic [1:0] MODE_WAVE = 2'd0;
   localparam logic [1:0] MODE_FULL = 2'd1;
   localparam logic [1:0] MODE_HALF = 2'd2;

   localparam logic [8:0] CENTRE = 9'd128;

   function automatic logic [3:0] half_pat(input logic [2:0] idx);
      case (idx)
         3'd0: return 4'b1000;
         3'd1: return 4'b1100;
         3'd2: return 4'b0100;
         3'd3: return 4'b0110;
         3'd4: return 4'b0010;
         3'd5: return 4'b0011;
         3'd6: return 4'b0001;
         3'd7: return 4'b1001;
      endcase
   endfunction

   // Wave uses the even entries directly; full (two coils on) uses the odd
   // entry that follows each even one.
   function automatic logic [3:0] step_pattern(input logic [2:0] idx, input logic [1:0] mode);
      if (mode == MODE_HALF || mode == MODE_WAVE) return half_pat(idx);
      return half_pat(idx | 3'd1);
   endfunction

endpackage

// File: rtl/adc_stepper_ctrl_step_phase_gen.sv
// Stepper phase generator: converts ch0 into speed/direction and walks the coil table.
//  clk, reset   : clock, async active-low reset
//  en           : 0 holds the step counter and phase, drops motor_en
//  mode         : wave / full / half stepping
//  ch0          : latest channel-0 conversion, 128 = stop
//  phase        : coil drive A,B,/A,/B
//  motor_en     : 2'b11 while moving
module step_phase_gen
   import adc_stepper_pkg::*;
#(
   parameter int STEP_BASE  = 2000,
   parameter int STEP_SCALE = 400,
   parameter int DEADBAND   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic [7:0] ch0,
   output logic [3:0] phase,
   output logic [1:0] motor_en
);

   localparam logic [31:0] DB = 32'(DEADBAND);

   logic [8:0]  d;
   logic [7:0]  mag;
   logic [6:0]  m;
   logic        stop;
   logic        fwd;
   logic        is_half;
   logic [31:0] period;
   logic [31:0] cnt;
   logic [2:0]  idx;
   logic [2:0]  base;
   logic [2:0]  idx_nxt;
   logic        moving;

   assign d       = {1'b0, ch0} - CENTRE;
   assign mag     = d[8] ? 8'(9'd0 - d) : d[7:0];
   assign m       = mag[7] ? 7'd127 : mag[6:0];
   assign stop    = 32'(m) <= DB;
   assign fwd     = ~d[8];
   assign is_half = (mode == MODE_HALF);
   assign period  = 32'(STEP_BASE) + (32'd127 - 32'(m)) * 32'(STEP_SCALE);

   // Full and wave only use even indices, so a mode change snaps to one.
   assign base    = is_half ? idx : {idx[2:1], 1'b0};
   assign idx_nxt = fwd ? base + (is_half ? 3'd1 : 3'd2)
                        : base - (is_half ? 3'd1 : 3'd2);

   // While stopped the counter sits at zero so a new ch0 is acted on at once.
   // The first step after reset energises the coils at the current index
   // instead of moving away from it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt    <= '0;
         idx    <= '0;
         phase  <= '0;
         moving <= 1'b0;
      end else if (!en) begin
         moving <= 1'b0;
      end else if (cnt != '0) begin
         cnt <= cnt - 32'd1;
      end else if (stop) begin
         moving <= 1'b0;
      end else begin
         moving <= 1'b1;
         cnt    <= period - 32'd1;
         if (phase == 4'b0000) begin
            idx   <= base;
            phase <= step_pattern(base, mode);
         end else begin
            idx   <= idx_nxt;
            phase <= step_pattern(idx_nxt, mode);
         end
      end
   end

   assign motor_en = moving ? 2'b11 : 2'b00;

endmodule

// File: rtl/adc_stepper_ctrl.sv
// ADC0809-style round-robin scan sequencer feeding a stepper phase generator.
//  clk, reset  : clock, async active-low reset
//  en          : enables scanning and motion
//  mode        : step mode for the phase generator
//  eoc, result : ADC end-of-conversion and data bus
//  adc_clk     : free-running divided ADC clock, starts low
//  addr, ale, start, out_en : ADC mux address and handshake strobes
//  ch_data     : latest result per channel, ch0 in [7:0]; led mirrors ch0
//  adc_err     : sticky conversion timeout flag
//  phase, motor_en : stepper coil drive and enable
//
// state   | meaning
// IDLE    | parked, waiting for en
// ADDR    | channel address settling
// ALE     | address latch pulse
// START   | start pulse, ADC_DIV cycles
// WBUSY   | waiting for eoc low
// WEOC    | waiting for eoc high
// READ    | out_en for 2 cycles, capture on the second
// NEXT    | advance channel, continue or park
module adc_stepper_ctrl
   import adc_stepper_pkg::*;
#(
   parameter int NUM_CH     = 2,
   parameter int ADC_DIV    = 25,
   parameter int EOC_TMO    = 4096,
   parameter int STEP_BASE  = 2000,
   parameter int STEP_SCALE = 400,
   parameter int DEADBAND   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic                eoc,
   input  logic [7:0]          result,
   output logic                adc_clk,
   output logic [2:0]          addr,
   output logic                ale,
   output logic                start,
   output logic                out_en,
   output logic [8*NUM_CH-1:0] ch_data,
   output logic [7:0]          led,
   output logic                adc_err,
   output logic [3:0]          phase,
   output logic [1:0]          motor_en
);

   localparam int TMR_MAX = (EOC_TMO > ADC_DIV) ? EOC_TMO : ADC_DIV;
   localparam int TW      = $clog2(TMR_MAX) + 1;
   localparam int DW      = $clog2(ADC_DIV) + 1;
   localparam logic [2:0] CH_LAST = 3'(NUM_CH - 1);

   adc_state_t    state, state_nxt;
   logic [TW-1:0] tmr, tmr_nxt;
   logic [DW-1:0] div_cnt;
   logic [2:0]    ch;
   logic [7:0]    ch_reg [NUM_CH];
   logic          capture;
   logic          set_err;
   logic          adv_ch;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt <= DW'(ADC_DIV - 1);
         adc_clk <= 1'b0;
      end else if (div_cnt == '0) begin
         div_cnt <= DW'(ADC_DIV - 1);
         adc_clk <= ~adc_clk;
      end else begin
         div_cnt <= div_cnt - DW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         tmr   <= '0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      tmr_nxt   = tmr;
      ale       = 1'b0;
      start     = 1'b0;
      out_en    = 1'b0;
      capture   = 1'b0;
      set_err   = 1'b0;
      adv_ch    = 1'b0;
      case (state)
         S_IDLE:  if (en) state_nxt = S_ADDR;
         S_ADDR:  state_nxt = S_ALE;
         S_ALE: begin
            ale       = 1'b1;
            state_nxt = S_START;
            tmr_nxt   = TW'(ADC_DIV - 1);
         end
         S_START: begin
            start = 1'b1;
            if (tmr == '0) begin
               state_nxt = S_WBUSY;
               tmr_nxt   = TW'(EOC_TMO - 1);
            end else begin
               tmr_nxt = tmr - TW'(1);
            end
         end
         S_WBUSY: begin
            if (!eoc) begin
               state_nxt = S_WEOC;
               tmr_nxt   = TW'(EOC_TMO - 1);
            end else if (tmr == '0) begin
               set_err   = 1'b1;
               state_nxt = S_NEXT;
            end else begin
               tmr_nxt = tmr - TW'(1);
            end
         end
         S_WEOC: begin
            if (eoc) begin
               state_nxt = S_READ;
               tmr_nxt   = TW'(1);
            end else if (tmr == '0) begin
               set_err   = 1'b1;
               state_nxt = S_NEXT;
            end else begin
               tmr_nxt = tmr - TW'(1);
            end
         end
         S_READ: begin
            out_en = 1'b1;
            if (tmr == '0) begin
               capture   = 1'b1;
               state_nxt = S_NEXT;
            end else begin
               tmr_nxt = tmr - TW'(1);
            end
         end
         S_NEXT: begin
            adv_ch    = 1'b1;
            state_nxt = en ? S_ADDR : S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ch      <= '0;
         adc_err <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) ch_reg[i] <= '0;
      end else begin
         if (adv_ch) ch <= (ch == CH_LAST) ? 3'd0 : ch + 3'd1;
         if (set_err) adc_err <= 1'b1;
         if (capture) begin
            for (int i = 0; i < NUM_CH; i++)
               if (ch == 3'(i)) ch_reg[i] <= result;
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign ch_data[8*g +: 8] = ch_reg[g];
   end

   assign addr = ch;
   assign led  = ch_reg[0];

   step_phase_gen #(
      .STEP_BASE  (STEP_BASE),
      .STEP_SCALE (STEP_SCALE),
      .DEADBAND   (DEADBAND)
   ) u_step (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .mode     (mode),
      .ch0      (ch_reg[0]),
      .phase    (phase),
      .motor_en (motor_en)
   );

endmodule

// File: tb/tb_adc_stepper_ctrl.sv
module tb_adc_stepper_ctrl;

   logic        clk;
   logic        reset;
   logic        en;
   logic [1:0]  mode;
   logic        eoc;
   logic [7:0]  result;
   logic        adc_clk;
   logic [2:0]  addr;
   logic        ale;
   logic        start;
   logic        out_en;
   logic [15:0] ch_data;
   logic [7:0]  led;
   logic        adc_err;
   logic [3:0]  phase;
   logic [1:0]  motor_en;

   int          n_tests = 0;
   int          n_fail  = 0;

   logic [7:0]  adc_val [2];
   bit          eoc_stuck;
   logic [3:0]  ph_ref;

   logic [2:0]  exp_addr_q  [$];
   logic [7:0]  exp_data_q  [$];
   logic [3:0]  exp_phase_q [$];

   localparam int C_ALE   = 0;
   localparam int C_OE    = 1;
   localparam int C_NOE   = 2;
   localparam int C_ERR   = 3;
   localparam int C_PHCHG = 4;
   localparam int C_MSTOP = 5;

   adc_stepper_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .mode     (mode),
      .eoc      (eoc),
      .result   (result),
      .adc_clk  (adc_clk),
      .addr     (addr),
      .ale      (ale),
      .start    (start),
      .out_en   (out_en),
      .ch_data  (ch_data),
      .led      (led),
      .adc_err  (adc_err),
      .phase    (phase),
      .motor_en (motor_en)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ADC model: eoc drops while start is high, rises 100 clk after start ends.
   initial begin : adc_model
      int         conv_cnt;
      bit         busy;
      logic [2:0] lat;
      eoc      = 1'b1;
      result   = '0;
      conv_cnt = 0;
      busy     = 1'b0;
      lat      = '0;
      forever begin
         @(negedge clk);
         if (ale) lat = addr;
         if (eoc_stuck) begin
            eoc  = 1'b1;
            busy = 1'b0;
         end else if (start) begin
            eoc      = 1'b0;
            busy     = 1'b1;
            conv_cnt = 100;
         end else if (busy) begin
            if (conv_cnt == 0) begin
               result = adc_val[lat[0]];
               eoc    = 1'b1;
               busy   = 1'b0;
            end else begin
               conv_cnt--;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit cond(input int sel);
      case (sel)
         C_ALE:   return ale;
         C_OE:    return out_en;
         C_NOE:   return !out_en;
         C_ERR:   return adc_err;
         C_PHCHG: return phase !== ph_ref;
         C_MSTOP: return motor_en == 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int budget, input string tag, output int cycles);
      cycles = 0;
      while (!cond(sel) && cycles < budget) begin
         @(negedge clk);
         cycles++;
      end
      check({tag, "_wait"}, 32'(cond(sel)), 32'd1);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_adc_clk"},  32'(adc_clk),  0);
      check({tag, "_addr"},     32'(addr),     0);
      check({tag, "_ale"},      32'(ale),      0);
      check({tag, "_start"},    32'(start),    0);
      check({tag, "_out_en"},   32'(out_en),   0);
      check({tag, "_ch_data"},  32'(ch_data),  0);
      check({tag, "_led"},      32'(led),      0);
      check({tag, "_adc_err"},  32'(adc_err),  0);
      check({tag, "_phase"},    32'(phase),    0);
      check({tag, "_motor_en"}, 32'(motor_en), 0);
   endtask

   // Consumes the expected phase queue; each entry must be the very next
   // phase change. first_gap = 0 skips the interval check on the first one.
   task automatic expect_steps(input string tag, input int first_gap);
      int         cyc;
      int         k;
      logic [3:0] exp;
      k = 0;
      while (exp_phase_q.size() > 0) begin
         exp    = exp_phase_q.pop_front();
         ph_ref = phase;
         wait_for(C_PHCHG, 2300, tag, cyc);
         check({tag, "_phase"}, 32'(phase), 32'(exp));
         if (k > 0 || first_gap > 0)
            check({tag, "_period"}, cyc, (k > 0) ? 2000 : first_gap);
         k++;
      end
   endtask

   initial begin : main
      int         cyc;
      int         ec;
      logic [2:0] s;

      reset     = 1'b0;
      en        = 1'b0;
      mode      = 2'd2;
      eoc_stuck = 1'b0;
      adc_val[0] = 8'h40;
      adc_val[1] = 8'hC0;
      ph_ref    = '0;

      repeat (3) @(negedge clk);
      check_zero("por");
      reset = 1'b1;

      // adc_clk: first rising edge after ADC_DIV cycles
      cyc = 0;
      while (!adc_clk && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      check("adc_clk_half", cyc, 25);

      // Scan: addr 0,1,0 with single ale, 25-cycle start, 2-cycle out_en
      en = 1'b1;
      exp_addr_q.push_back(3'd0); exp_data_q.push_back(8'h40);
      exp_addr_q.push_back(3'd1); exp_data_q.push_back(8'hC0);
      exp_addr_q.push_back(3'd0); exp_data_q.push_back(8'h40);
      for (int k = 0; k < 3; k++) begin
         wait_for(C_ALE, 300, "scan_ale", cyc);
         ec = int'(exp_addr_q[0]);
         check("scan_addr", 32'(addr), 32'(exp_addr_q.pop_front()));
         @(negedge clk);
         check("ale_width", 32'(ale), 0);
         cyc = 0;
         while (start && cyc < 100) begin
            @(negedge clk);
            cyc++;
         end
         check("start_width", cyc, 25);
         wait_for(C_OE, 300, "scan_oe", cyc);
         cyc = 0;
         while (out_en && cyc < 10) begin
            @(negedge clk);
            cyc++;
         end
         check("oe_width", cyc, 2);
         check("scan_data", 32'(ch_data[8*ec +: 8]), 32'(exp_data_q.pop_front()));
      end
      check("ch_data_all", 32'(ch_data), 32'h0000C040);
      check("led", 32'(led), 32'h40);

      // Forward half stepping from reset: 1000 immediately, then 2000-cycle steps
      reset = 1'b0;
      en    = 1'b0;
      @(negedge clk);
      reset      = 1'b1;
      adc_val[0] = 8'hFF;
      mode       = 2'd2;
      en         = 1'b1;
      exp_phase_q.push_back(4'b1000);
      exp_phase_q.push_back(4'b1100);
      exp_phase_q.push_back(4'b0100);
      exp_phase_q.push_back(4'b0110);
      expect_steps("half_fwd", 1);
      check("fwd_motor_en", 32'(motor_en), 32'h3);

      // Half -> wave at index 3 lands on index 4
      mode = 2'd0;
      exp_phase_q.push_back(4'b0010);
      expect_steps("wave_realign", 2000);

      // Full reverse
      mode       = 2'd1;
      adc_val[0] = 8'h00;
      exp_phase_q.push_back(4'b0110);
      exp_phase_q.push_back(4'b1100);
      exp_phase_q.push_back(4'b1001);
      exp_phase_q.push_back(4'b0011);
      expect_steps("full_rev", 2000);

      // Deadband stop
      adc_val[0] = 8'h84;
      wait_for(C_MSTOP, 2300, "stop", cyc);
      check("stop_phase", 32'(phase), 32'h3);
      repeat (3000) @(negedge clk);
      check("stop_hold_phase", 32'(phase), 32'h3);
      check("stop_hold_men", 32'(motor_en), 0);

      // Stuck eoc: timeout after EOC_TMO, next channel, data kept
      wait_for(C_OE, 400, "pre_tmo_oe", cyc);
      wait_for(C_NOE, 10, "pre_tmo_noe", cyc);
      eoc_stuck = 1'b1;
      wait_for(C_ALE, 10, "tmo_ale", cyc);
      s = addr;
      exp_addr_q.push_back((s == 3'd0) ? 3'd1 : 3'd0);
      @(negedge clk);
      cyc = 0;
      while (start && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      wait_for(C_ERR, 5000, "tmo_err", cyc);
      check("tmo_cycles", cyc, 4096);
      check("tmo_data_kept", 32'(ch_data), 32'h0000C084);
      wait_for(C_ALE, 10, "tmo_next_ale", cyc);
      check("tmo_next_addr", 32'(addr), 32'(exp_addr_q.pop_front()));
      eoc_stuck = 1'b0;
      wait_for(C_OE, 400, "post_tmo_oe", cyc);
      wait_for(C_NOE, 10, "post_tmo_noe", cyc);
      check("err_sticky", 32'(adc_err), 1);
      check("post_tmo_data", 32'(ch_data), 32'h0000C084);

      // Async reset mid-READ while moving
      adc_val[0] = 8'hFF;
      mode       = 2'd0;
      exp_phase_q.push_back(4'b0001);
      expect_steps("resume_wave", 0);
      wait_for(C_OE, 400, "rst_oe", cyc);
      #2 reset = 1'b0;
      #1 check_zero("async_rst");
      en   = 1'b0;
      mode = 2'd3;
      @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_en0_phase", 32'(phase), 0);
      check("rst_en0_men", 32'(motor_en), 0);
      check("rst_err_clear", 32'(adc_err), 0);
      en     = 1'b1;
      ph_ref = phase;
      wait_for(C_PHCHG, 10, "mode3_first", cyc);
      check("mode3_first_phase", 32'(phase), 32'b1100);
      exp_addr_q.push_back(3'd0);
      wait_for(C_ALE, 10, "rst_ale", cyc);
      check("rst_scan_addr", 32'(addr), 32'(exp_addr_q.pop_front()));
      exp_phase_q.push_back(4'b0110);
      expect_steps("mode3_fwd", 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
